// File: rtl/stereo_frame_feeder.sv
// Captures one decimated frame per camera into a left/right bank pair, then
// serves both banks in raster order over a request/valid read port.
module stereo_frame_feeder #(
    parameter int unsigned SRC_WIDTH  = 736,
    parameter int unsigned SRC_HEIGHT = 480,
    parameter int unsigned SCALE      = 16,
    parameter int unsigned WIDTH      = 46,
    parameter int unsigned HEIGHT     = 30,
    localparam int unsigned DW        = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [DW-1:0] cam_data,
    input  logic          cam_valid,
    input  logic          cam_href,
    input  logic          cam_vref,
    input  logic          cam_sel,
    input  logic          image_sel,
    input  logic          rd_en,
    output logic [DW-1:0] image_data,
    output logic          data_valid,
    output logic          buffer_ready,
    output logic          frame_done,
    output logic          overrun
);
    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned AW    = 11;
    localparam int unsigned CW    = 10;
    localparam logic [AW-1:0] LAST_CNT   = AW'(TOTAL);
    localparam logic [AW-1:0] FINAL_ADDR = AW'(TOTAL - 1);
    localparam logic [CW-1:0] SCALE_MASK = CW'(SCALE - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SERVE} state_t;

    state_t        state, state_nx;
    logic          href_d, vref_d;
    logic [CW-1:0] col_cnt, line_cnt;
    logic          target;
    logic [1:0]    bank_valid;
    logic          wr_pend;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] ptr_l, ptr_r;
    logic [DW-1:0] mem_l [TOTAL];
    logic [DW-1:0] mem_r [TOTAL];

    logic          href_rise, href_fall, vref_rise, vref_fall, beat;
    logic [CW-1:0] col_idx;
    logic          sample, arm_take, cap_done, cap_abort;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok, rd_over, last_rd;

    assign href_rise = cam_href & ~href_d;
    assign href_fall = ~cam_href & href_d;
    assign vref_rise = cam_vref & ~vref_d;
    assign vref_fall = ~cam_vref & vref_d;
    assign beat      = cam_valid & cam_href;
    // A beat that coincides with the href rise is column 0 of the new line.
    assign col_idx   = href_rise ? '0 : col_cnt;

    assign sample    = (state == CAPTURE) && beat
                     && ((col_idx & SCALE_MASK) == '0) && ((line_cnt & SCALE_MASK) == '0)
                     && (col_idx < CW'(SRC_WIDTH)) && (line_cnt < CW'(SRC_HEIGHT));
    assign arm_take  = (state == ARMED) && vref_rise && !bank_valid[cam_sel];
    assign cap_done  = (state == CAPTURE) && (wr_cnt == LAST_CNT);
    // A final write still in flight when vref falls still completes the bank.
    assign cap_abort = (state == CAPTURE) && vref_fall && !cap_done
                     && !(wr_pend && (wr_cnt == FINAL_ADDR));

    assign rd_ptr    = image_sel ? ptr_r : ptr_l;
    assign rd_ok     = (state == SERVE) && rd_en && (rd_ptr != LAST_CNT);
    assign rd_over   = (state == SERVE) && rd_en && (rd_ptr == LAST_CNT);
    assign last_rd   = rd_ok && image_sel && (ptr_r == FINAL_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = ARMED;
            ARMED:   if (arm_take) state_nx = CAPTURE;
            CAPTURE: begin
                if (cap_done)       state_nx = bank_valid[~target] ? SERVE : ARMED;
                else if (cap_abort) state_nx = ARMED;
            end
            SERVE:   if (last_rd) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture counters and write pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            href_d   <= 1'b0;
            vref_d   <= 1'b0;
            col_cnt  <= '0;
            line_cnt <= '0;
            target   <= 1'b0;
            wr_pend  <= 1'b0;
            wr_data  <= '0;
            wr_cnt   <= '0;
        end else begin
            href_d  <= cam_href;
            vref_d  <= cam_vref;
            wr_pend <= sample;
            wr_data <= cam_data;
            if (arm_take) begin
                target   <= cam_sel;
                col_cnt  <= '0;
                line_cnt <= '0;
                wr_cnt   <= '0;
            end else begin
                if (state == CAPTURE) begin
                    if (href_rise)  col_cnt <= beat ? CW'(1) : '0;
                    else if (beat)  col_cnt <= col_cnt + CW'(1);
                    if (href_fall)  line_cnt <= line_cnt + CW'(1);
                end
                if (wr_pend) wr_cnt <= wr_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend) begin
            if (target) mem_r[wr_cnt] <= wr_data;
            else        mem_l[wr_cnt] <= wr_data;
        end
    end

    // Bank flags, read pointers and registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_valid   <= '0;
            ptr_l        <= '0;
            ptr_r        <= '0;
            image_data   <= '0;
            data_valid   <= 1'b0;
            buffer_ready <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (state == IDLE)  bank_valid <= '0;
            else if (cap_done)  bank_valid[target] <= 1'b1;
            else if (last_rd)   bank_valid <= '0;

            if (state == IDLE) begin
                ptr_l <= '0;
                ptr_r <= '0;
            end else if (rd_ok) begin
                if (image_sel) ptr_r <= ptr_r + AW'(1);
                else           ptr_l <= ptr_l + AW'(1);
            end

            if (rd_ok) image_data <= image_sel ? mem_r[ptr_r] : mem_l[ptr_l];
            data_valid   <= rd_ok;
            frame_done   <= last_rd;
            buffer_ready <= (state_nx == SERVE);

            if ((state == IDLE) && enable) overrun <= 1'b0;
            else if (rd_over)              overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stereo_frame_feeder.sv
// Directed bench for stereo_frame_feeder using a reduced 64x48 source, SCALE 8.
`timescale 1ns/1ps
module tb_stereo_frame_feeder;
    localparam int SW = 64;
    localparam int SH = 48;
    localparam int SC = 8;
    localparam int W  = SW / SC;
    localparam int H  = SH / SC;
    localparam int TOTAL = W * H;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] cam_data = '0;
    logic       cam_valid = 1'b0;
    logic       cam_href = 1'b0;
    logic       cam_vref = 1'b0;
    logic       cam_sel = 1'b0;
    logic       image_sel = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] image_data;
    logic       data_valid;
    logic       buffer_ready;
    logic       frame_done;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rd;
        logic       sel;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;
    vec_t tv [17];

    stereo_frame_feeder #(
        .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .SCALE(SC), .WIDTH(W), .HEIGHT(H)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .cam_data(cam_data), .cam_valid(cam_valid), .cam_href(cam_href),
        .cam_vref(cam_vref), .cam_sel(cam_sel),
        .image_sel(image_sel), .rd_en(rd_en),
        .image_data(image_data), .data_valid(data_valid),
        .buffer_ready(buffer_ready), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic sel, input int idx);
        int r = idx / W;
        int c = idx % W;
        if (sel) return 8'(c * SC);
        return 8'((r * SC) ^ (c * SC));
    endfunction

    function automatic logic [7:0] src_pix(input int pat, input int l, input int c);
        case (pat)
            0:       return 8'(l) ^ 8'(c);
            1:       return 8'(c);
            2:       return ~8'(c);
            default: return 8'hA5;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One source line: 8 extra beats past SRC_WIDTH and stalled beats mixed in.
    task automatic send_line(input int pat, input int l);
        cam_href = 1'b1;
        for (int c = 0; c < SW + SC; c++) begin
            if (c % 5 == 3) begin
                cam_valid = 1'b0;
                @(negedge clk);
            end
            cam_valid = 1'b1;
            cam_data  = src_pix(pat, l, c);
            @(negedge clk);
        end
        cam_href  = 1'b0;
        cam_valid = 1'b0;
        cam_data  = '0;
        tick(2);
    endtask

    task automatic frame_start(input logic sel);
        cam_sel  = sel;
        cam_vref = 1'b1;
        tick(3);
    endtask

    task automatic frame_end();
        cam_vref = 1'b0;
        cam_sel  = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic sel, input int pat, input int lines);
        frame_start(sel);
        for (int l = 0; l < lines; l++) send_line(pat, l);
        frame_end();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_image_data"},   image_data,   0);
        check({tag, "_data_valid"},   data_valid,   0);
        check({tag, "_buffer_ready"}, buffer_ready, 0);
        check({tag, "_frame_done"},   frame_done,   0);
        check({tag, "_overrun"},      overrun,      0);
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    // Back-to-back reads of one bank from index start; frame_done expected on the last right pixel.
    task automatic rd_seq(input logic sel, input int start, input int n);
        logic fd;
        image_sel = sel;
        rd_en     = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) rd_en = 1'b0;
            fd = sel && (start + i == TOTAL - 1);
            check("seq_valid",        data_valid,   1);
            check("seq_data",         image_data,   exp_pix(sel, start + i));
            check("seq_frame_done",   frame_done,   fd);
            check("seq_buffer_ready", buffer_ready, !fd);
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b1, 8'd0};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 8'd0};
        tv[2]  = '{1'b1, 1'b0, 1'b1, 8'd8};
        tv[3]  = '{1'b1, 1'b1, 1'b1, 8'd8};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 8'd16};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 8'd0};
        tv[6]  = '{1'b1, 1'b1, 1'b1, 8'd16};
        tv[7]  = '{1'b1, 1'b0, 1'b1, 8'd24};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 8'd32};
        tv[9]  = '{1'b1, 1'b0, 1'b1, 8'd40};
        tv[10] = '{1'b1, 1'b1, 1'b1, 8'd24};
        tv[11] = '{1'b1, 1'b0, 1'b1, 8'd48};
        tv[12] = '{1'b1, 1'b0, 1'b1, 8'd56};
        tv[13] = '{1'b1, 1'b0, 1'b1, 8'd8};
        tv[14] = '{1'b1, 1'b1, 1'b1, 8'd32};
        tv[15] = '{1'b1, 1'b0, 1'b1, 8'd0};
        tv[16] = '{1'b1, 1'b1, 1'b1, 8'd40};

        tick(3);
        check_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // Full capture: left then right.
        pulse_enable();
        send_frame(1'b0, 0, SH);
        check("left_only_not_ready", buffer_ready, 0);
        send_frame(1'b1, 1, SH);
        check("both_ready", buffer_ready, 1);

        // Interleaved reads from the vector table.
        rd_en     = tv[0].rd;
        image_sel = tv[0].sel;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i + 1 < 17) begin
                rd_en     = tv[i + 1].rd;
                image_sel = tv[i + 1].sel;
            end else begin
                rd_en = 1'b0;
            end
            check($sformatf("tv%0d_valid", i), data_valid, tv[i].exp_valid);
            if (tv[i].exp_valid) check($sformatf("tv%0d_data", i), image_data, tv[i].exp_data);
            check($sformatf("tv%0d_overrun", i), overrun, 0);
        end
        @(negedge clk);
        check("idle_no_valid", data_valid, 0);

        // Drain left, then read past its end.
        rd_seq(1'b0, 10, TOTAL - 10);
        image_sel = 1'b0;
        rd_en     = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("overrun_no_valid", data_valid, 0);
        check("overrun_set", overrun, 1);
        check("overrun_still_ready", buffer_ready, 1);

        // Drain right; completion on the last pixel.
        rd_seq(1'b1, 6, TOTAL - 6);
        @(negedge clk);
        check("done_one_cycle", frame_done, 0);
        check("ready_dropped", buffer_ready, 0);
        check("overrun_sticky", overrun, 1);
        image_sel = 1'b0;
        rd_en     = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("idle_rd_ignored", data_valid, 0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("enable_clears_overrun", overrun, 0);

        // Short left, right, ignored second right, full left.
        send_frame(1'b0, 3, 20);
        check("short_not_ready", buffer_ready, 0);
        send_frame(1'b1, 1, SH);
        check("right_only_not_ready", buffer_ready, 0);
        send_frame(1'b1, 2, SH);
        check("second_right_ignored", buffer_ready, 0);
        send_frame(1'b0, 0, SH);
        check("recaptured_ready", buffer_ready, 1);
        rd_seq(1'b0, 0, TOTAL);
        rd_seq(1'b1, 0, TOTAL);
        @(negedge clk);
        check("second_done_ready", buffer_ready, 0);

        // Reset mid-capture.
        pulse_enable();
        frame_start(1'b0);
        for (int l = 0; l < 10; l++) send_line(0, l);
        reset_n = 1'b0;
        #1;
        check_zero("cap_reset");
        tick(2);
        reset_n = 1'b1;
        for (int l = 10; l < SH; l++) send_line(0, l);
        frame_end();
        check("post_reset_not_ready", buffer_ready, 0);
        image_sel = 1'b0;
        rd_en     = 1'b1;
        tick(2);
        rd_en = 1'b0;
        check("post_reset_no_valid", data_valid, 0);

        // Reset mid-serve.
        pulse_enable();
        send_frame(1'b0, 0, SH);
        send_frame(1'b1, 1, SH);
        check("serve_ready", buffer_ready, 1);
        rd_seq(1'b0, 0, 5);
        image_sel = 1'b0;
        rd_en     = 1'b1;
        @(negedge clk);
        check("pre_reset_valid", data_valid, 1);
        check("pre_reset_data", image_data, exp_pix(1'b0, 5));
        reset_n = 1'b0;
        #1;
        check_zero("serve_reset");
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("after_reset_rd_valid", data_valid, 0);
        check("after_reset_ready", buffer_ready, 0);
        check("after_reset_overrun", overrun, 0);
        rd_en = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stereo_frame_feeder.md
# stereo_frame_feeder

Captures one decimated grayscale frame from each camera into a two-bank on-chip store, then serves the stored frames to the disparity engine in raster order over a request/valid read port. It sits between the camera capture path (OV7670-style `href`/`vref` timing) and the disparity FSM's `image_data`/`buffer_ready`/`image_sel` read interface. Scaling matches the disparity engine's output geometry: 736x480 source to 46x30.

## Interface
- `SRC_WIDTH`, 736: active source pixels per line.
- `SRC_HEIGHT`, 480: active source lines per frame.
- `SCALE`, 16: decimation factor in both axes. Must be a power of two.
- `WIDTH`, 46: stored frame width, equal to `SRC_WIDTH/SCALE`.
- `HEIGHT`, 30: stored frame height, equal to `SRC_HEIGHT/SCALE`.
- `clk`  in  1  single clock for capture and read.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arms a new capture of both banks. Honoured only in IDLE.
- `cam_data`  in  8  source pixel (luma).
- `cam_valid`  in  1  `cam_data` is valid this cycle.
- `cam_href`  in  1  active line.
- `cam_vref`  in  1  active frame. High for the whole frame.
- `cam_sel`  in  1  source camera: 0 = left, 1 = right. Sampled on the `cam_vref` rising edge.
- `image_sel`  in  1  bank the consumer reads: 0 = left, 1 = right.
- `rd_en`  in  1  read request for the next pixel of the selected bank.
- `image_data`  out  8  read pixel.
- `data_valid`  out  1  `image_data` is valid this cycle.
- `buffer_ready`  out  1  both banks are captured and may be read.
- `frame_done`  out  1  one-cycle pulse after the last right-bank pixel is returned.
- `overrun`  out  1  sticky flag: `rd_en` was asserted past the end of a bank. Cleared on the next `enable`.

## Operation
- **Storage:** two banks of `WIDTH*HEIGHT` bytes (1380 each). Address = `row*WIDTH + col`, 11 bits. Each bank has a valid flag.
- **States:** IDLE, ARMED, CAPTURE, SERVE.
- **IDLE:**
  - `enable` → ARMED.
  - Clears both valid flags and `overrun`, and resets both read pointers.
- **ARMED:** on a `cam_vref` rising edge, latch `cam_sel` as the target bank and go to CAPTURE.
  - If the target bank is already valid, ignore that frame and stay in ARMED.
- **CAPTURE:** counts source pixels and lines and writes decimated samples.
  - Source column counter (10 bits) counts beats with `cam_valid && cam_href`. It clears on each `cam_href` rising edge.
  - Source line counter (10 bits) increments on each `cam_href` falling edge.
  - A pixel is written when column mod `SCALE` = 0, line mod `SCALE` = 0, column < `SRC_WIDTH` and line < `SRC_HEIGHT`. This keeps the top-left pixel of each block (no averaging).
  - The write address increments per write.
  - After write number `WIDTH*HEIGHT`, set the target bank's valid flag on the next cycle.
    - If both flags are now set → SERVE.
    - Otherwise → ARMED.
  - If `cam_vref` falls before `WIDTH*HEIGHT` writes, discard the bank (flag stays 0) → ARMED.
- **SERVE:**
  - `buffer_ready` = 1.
  - Each bank has its own 11-bit read pointer. `rd_en` reads the bank given by `image_sel` at its pointer, then increments that pointer.
  - `rd_en` when the selected pointer equals `WIDTH*HEIGHT`: no read, no `data_valid`, set `overrun`.
  - When the right pointer reaches `WIDTH*HEIGHT` and its final data is returned:
    - pulse `frame_done`;
    - clear both valid flags;
    - → IDLE.
  - The left bank may still be unread at this point.
- **Ignored inputs:**
  - `rd_en` outside SERVE is ignored (no `data_valid`, no overrun).
  - `enable` outside IDLE is ignored.
  - Camera inputs in IDLE and SERVE are ignored.
- **Reset (`reset_n` low, any state):**
  - state → IDLE;
  - all counters, pointers and flags → 0;
  - all outputs → 0: `image_data`, `data_valid`, `buffer_ready`, `frame_done`, `overrun`.
  - Memory contents are undefined.

## Timing
- **Read latency:** `rd_en` sampled at edge N → `image_data` and `data_valid` at edge N+1 (registered RAM read).
  - `rd_en` may be held high for back-to-back reads at 1 pixel/clock.
- **`image_sel`:** sampled in the same cycle as `rd_en`. Switching between requests is legal and takes effect immediately.
- **Capture write:** occurs in the cycle after the qualifying camera beat. The valid flag sets 1 cycle after the final write.
- **`buffer_ready`:** rises in the first SERVE cycle and falls in the same cycle `frame_done` pulses.
- **Simultaneous events:** a `cam_vref` rise in the same cycle as entering ARMED is taken. A `cam_href` rise and `cam_valid` in the same cycle counts that beat as column 0.

## Test plan
- **Full capture:** `enable`, then a left frame (`cam_data` = `line[7:0] ^ col[7:0]`), then a right frame (`cam_data` = `col[7:0]`) → `buffer_ready` = 1.
  - Left reads 0..1379 return `(16r)^(16c)` in raster order.
  - Right reads return `16c`.
  - `data_valid` is exactly 1 cycle after each `rd_en`.
- **Completion:** 1380 back-to-back right reads → `frame_done` pulses with the last `data_valid`. `buffer_ready` drops and the block returns to IDLE.
- **Overrun:** extra `rd_en` on the left bank after 1380 reads → no `data_valid`, `overrun` = 1. The next `enable` clears it.
- **Short frame:** `cam_vref` drops after 200 lines → left flag stays 0. The next full left frame is accepted. Two consecutive right frames → the second is ignored.
- **Reset mid-operation:** `reset_n` low mid-CAPTURE and mid-SERVE → all outputs 0 on the next cycle. `rd_en` then yields nothing until a new capture completes.
- **Interleaved reads:** reads alternating `image_sel` every cycle → each bank's pointer advances independently and the data matches both patterns.
